instr_boot_loader: RTL and testbench
====================================

INSTR_BOOT_LOADER -- requirements
Module: instr_boot_loader

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000: byte address written by the first instruction word.
REQ-002 Parameter MAX_WORDS, default 256: largest accepted program length in words.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle pulse; arms a load when in IDLE or DONE, ignored otherwise.
REQ-006 byte_valid  input  1  stream byte present.
REQ-007 byte_data  input  8  stream byte.
REQ-008 byte_ready  output  1  loader accepts byte_data this cycle; transfer = byte_valid & byte_ready.
REQ-009 instwen  output  1  instruction-memory write enable, one cycle per word.
REQ-010 addwrite  output  32  instruction-memory byte address, qualified by instwen.
REQ-011 instrdatain  output  32  instruction word, qualified by instwen.
REQ-012 cpu_hold  output  1  high holds the processor in reset while loading.
REQ-013 busy  output  1  load in progress.
REQ-014 done  output  1  load finished, sticky until next start.
REQ-015 err  output  1  length error, sticky until next start.
REQ-016 word_count  output  16  words written in the current or last load.

Function
REQ-017 Stream format: 2 length bytes N (big-endian, 16-bit), then 4*N instruction bytes, each word big-endian (first byte = instrdatain[31:24]).
REQ-018 FSM states: IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE.
REQ-019 IDLE/DONE + start -> LEN_HI; done, err and word_count clear and busy rises on the next cycle.
REQ-020 LEN_HI -> LEN_LO on a transfer; LEN_LO -> DATA on a transfer; at LEN_LO exit, N=0 -> DONE, and N>MAX_WORDS -> DONE with err=1.
REQ-021 On an error, no instwen pulses occur, and the remaining stream bytes are not consumed.
REQ-022 byte_ready=1 only in LEN_HI, LEN_LO and DATA; byte_ready is 0 in WRITE, so the loader never drops a byte.
REQ-023 DATA: a byte counter (0..3) shifts bytes into a 32-bit assembly register; the 4th transfer -> WRITE.
REQ-024 WRITE lasts exactly one cycle: instwen=1, addwrite=BASE_ADDR+4*word_count, instrdatain=assembled word; word_count increments at the end of the cycle.
REQ-025 After WRITE: word_count==N -> DONE, else -> DATA.
REQ-026 Throughput: 5 cycles per word with byte_valid held high; stalls on byte_valid=0 are unbounded and change no state.
REQ-027 addwrite wraps modulo 2^32 without error.
REQ-028 cpu_hold=1 in every state except DONE with err=0; cpu_hold falls in the same cycle done rises.
REQ-029 A start pulse while busy=1 is ignored and does not restart the load.
REQ-030 instwen=0, addwrite=0 and instrdatain=0 in every state other than WRITE.

Reset
REQ-031 reset low at any time, including mid-word or mid-WRITE, forces IDLE asynchronously.
REQ-032 Reset values: byte_ready=0, instwen=0, addwrite=0, instrdatain=0, cpu_hold=1, busy=0, done=0, err=0, word_count=0.
REQ-033 A partially assembled word is discarded on reset and is never written.

Structure
REQ-034 The FSM state enum, the length-field width (16) and the bytes-per-word constant (4) shall reside in the shared verification/design package.
REQ-035 One sub-module, byte_word_packer, shall hold the byte counter and the assembly register, and shall signal word_ready.

Verification
REQ-036 Stream 00 02 | 24 08 00 05 | 20 09 00 07 with byte_valid constant: instwen at addr 0 data 0x24080005, then at addr 4 data 0x20090007; done=1, word_count=2, cpu_hold=0.
REQ-037 Stream 00 00: done=1 with zero instwen pulses, err=0.
REQ-038 Length 0x0101 with MAX_WORDS=256: err=1, done=1, cpu_hold=1, no instwen pulses.
REQ-039 Random byte_valid gaps on a 3-word load: written data and addresses identical to the gap-free run.
REQ-040 Reset asserted after the 2nd byte of word 1: outputs return to reset values, no instwen; a new start reloads correctly.
REQ-041 start pulsed during DATA: ignored; load completes with the original N.

Source files
------------

// File: rtl/instr_boot_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : instr_boot_loader_pkg
//  Description : Shared types and constants for the instruction boot loader:
//                FSM state encoding, length-field width, bytes per word and an
//                address helper.
//  Revision    : 1.0  initial release
// ============================================================================
package instr_boot_loader_pkg;

    // Width of the big-endian program-length header, in bits
    localparam int c_len_w          = 16;

    // Instruction words are assembled from this many stream bytes
    localparam int c_bytes_per_word = 4;

    // Width of the byte-within-word counter
    localparam int c_byte_cnt_w     = $clog2(c_bytes_per_word);

    // Loader control states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5
    } boot_state_t;

    // Byte address of word number idx relative to base; wraps modulo 2^32
    function automatic logic [31:0] word_addr(input logic [31:0]        base,
                                              input logic [c_len_w-1:0] idx);
        return base + {{(32-c_len_w-2){1'b0}}, idx, 2'b00};
    endfunction

endpackage : instr_boot_loader_pkg
`default_nettype wire

// File: rtl/instr_boot_loader_byte_word_packer.sv
`default_nettype none
// ============================================================================
//  Module      : byte_word_packer
//  Description : Collects stream bytes into big-endian 32-bit words. The first
//                three bytes are held in the assembly register; the fourth is
//                passed straight through so the complete word is presented on
//                the same cycle as the fourth transfer, together with
//                word_ready.
//  Revision    : 1.0  initial release
// ============================================================================
module byte_word_packer
    import instr_boot_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,       // asynchronous, active low
    input  logic        clear,       // synchronous flush of any partial word
    input  logic        shift_en,    // a data byte is transferred this cycle
    input  logic [7:0]  byte_in,
    output logic        word_ready,  // fourth byte of a word is being accepted
    output logic [31:0] word_out     // assembled word, valid with word_ready
);

    localparam int                      c_held_w   = 8 * (c_bytes_per_word - 1);
    localparam logic [c_byte_cnt_w-1:0] c_last_idx = c_byte_cnt_w'(c_bytes_per_word - 1);
    localparam logic [c_byte_cnt_w-1:0] c_cnt_one  = c_byte_cnt_w'(1);

    logic [c_byte_cnt_w-1:0] r_count;
    logic [c_held_w-1:0]     r_assy;

    // Byte counter and assembly shift register; first byte ends up in [31:24]
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_assy  <= '0;
        end else if (clear) begin
            r_count <= '0;
            r_assy  <= '0;
        end else if (shift_en) begin
            r_assy  <= {r_assy[c_held_w-9:0], byte_in};
            r_count <= r_count + c_cnt_one;   // wraps to 0 after the last byte
        end
    end

    // Word completes on the transfer that carries the last byte
    always_comb begin
        word_ready = shift_en && (r_count == c_last_idx);
        word_out   = {r_assy, byte_in};
    end

endmodule : byte_word_packer
`default_nettype wire

// File: rtl/instr_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : instr_boot_loader
//  Description : Loads a length-prefixed byte stream into instruction memory.
//                Stream: 16-bit big-endian word count N, then N big-endian
//                32-bit words. Each word is written in a single WRITE cycle
//                at BASE_ADDR + 4*index while the CPU is held in reset.
//  Revision    : 1.0  initial release
// ============================================================================
module instr_boot_loader
    import instr_boot_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic               clk,
    input  logic               reset,        // asynchronous, active low
    input  logic               start,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic               byte_ready,
    output logic               instwen,
    output logic [31:0]        addwrite,
    output logic [31:0]        instrdatain,
    output logic               cpu_hold,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic [c_len_w-1:0] word_count
);

    localparam logic [31:0]        c_max_words = 32'(MAX_WORDS);
    localparam logic [c_len_w-1:0] c_cnt_one   = c_len_w'(1);

    boot_state_t        r_state;
    logic [7:0]         r_len_hi;
    logic [c_len_w-1:0] r_len;

    logic               w_xfer;
    logic               w_arm;
    logic               w_shift_en;
    logic [c_len_w-1:0] w_len;
    logic [c_len_w-1:0] w_count_nxt;
    logic               w_word_ready;
    logic [31:0]        w_word;

    // Handshake, start qualification and derived length/count values
    always_comb begin
        w_xfer      = byte_valid && byte_ready;
        w_arm       = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
        w_shift_en  = w_xfer && (r_state == ST_DATA);
        w_len       = {r_len_hi, byte_data};
        w_count_nxt = word_count + c_cnt_one;
    end

    byte_word_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (w_arm),
        .shift_en   (w_shift_en),
        .byte_in    (byte_data),
        .word_ready (w_word_ready),
        .word_out   (w_word)
    );

    // Loader FSM; every output is registered and updated on state entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_len_hi    <= '0;
            r_len       <= '0;
            byte_ready  <= 1'b0;
            instwen     <= 1'b0;
            addwrite    <= '0;
            instrdatain <= '0;
            cpu_hold    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            word_count  <= '0;
        end else begin
            case (r_state)
                // Start is honoured only when no load is in flight
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        r_state    <= ST_LEN_HI;
                        byte_ready <= 1'b1;
                        busy       <= 1'b1;
                        cpu_hold   <= 1'b1;
                        done       <= 1'b0;
                        err        <= 1'b0;
                        word_count <= '0;
                    end
                end

                ST_LEN_HI: begin
                    if (w_xfer) begin
                        r_len_hi <= byte_data;
                        r_state  <= ST_LEN_LO;
                    end
                end

                // Length is validated before any data byte is accepted, so an
                // oversize program leaves the rest of the stream untouched
                ST_LEN_LO: begin
                    if (w_xfer) begin
                        r_len <= w_len;
                        if (w_len == '0) begin
                            r_state    <= ST_DONE;
                            byte_ready <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            cpu_hold   <= 1'b0;
                        end else if (32'(w_len) > c_max_words) begin
                            r_state    <= ST_DONE;
                            byte_ready <= 1'b0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            err        <= 1'b1;
                            cpu_hold   <= 1'b1;   // processor stays held on error
                        end else begin
                            r_state    <= ST_DATA;
                        end
                    end
                end

                // Fourth byte of a word: stop accepting and present the write
                ST_DATA: begin
                    if (w_word_ready) begin
                        r_state     <= ST_WRITE;
                        byte_ready  <= 1'b0;
                        instwen     <= 1'b1;
                        addwrite    <= word_addr(BASE_ADDR, word_count);
                        instrdatain <= w_word;
                    end
                end

                // Single write cycle, then either finish or fetch the next word
                ST_WRITE: begin
                    instwen     <= 1'b0;
                    addwrite    <= '0;
                    instrdatain <= '0;
                    word_count  <= w_count_nxt;
                    if (w_count_nxt == r_len) begin
                        r_state  <= ST_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        cpu_hold <= 1'b0;
                    end else begin
                        r_state    <= ST_DATA;
                        byte_ready <= 1'b1;
                    end
                end

                default: begin
                    r_state     <= ST_IDLE;
                    byte_ready  <= 1'b0;
                    instwen     <= 1'b0;
                    addwrite    <= '0;
                    instrdatain <= '0;
                    cpu_hold    <= 1'b1;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule : instr_boot_loader
`default_nettype wire

// File: tb/tb_instr_boot_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instr_boot_loader
//  Description : Self-checking bench for instr_boot_loader. Expected memory
//                writes are queued as the stream is driven and compared as
//                instwen pulses appear.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_instr_boot_loader;

    localparam logic [31:0] c_base = 32'h0000_0000;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk;
    logic        reset;
    logic        start;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        instwen;
    logic [31:0] addwrite;
    logic [31:0] instrdatain;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] word_count;

    int          errors = 0;
    int          checks = 0;
    int          wr_cnt = 0;
    int          cyc = 0;
    int          last_wr_cyc = 0;
    int          prev_wr_cyc = 0;
    wr_t         sb_q[$];
    wr_t         exp_wr;
    logic [31:0] words [0:255];

    instr_boot_loader #(
        .BASE_ADDR (c_base),
        .MAX_WORDS (256)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .byte_ready  (byte_ready),
        .instwen     (instwen),
        .addwrite    (addwrite),
        .instrdatain (instrdatain),
        .cpu_hold    (cpu_hold),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .word_count  (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        if (obs !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Write monitor: pop scoreboard on instwen, bus must be quiet otherwise
    always @(negedge clk) begin
        if (reset) begin
            if (instwen) begin
                wr_cnt++;
                prev_wr_cyc = last_wr_cyc;
                last_wr_cyc = cyc;
                if (sb_q.size() == 0) begin
                    check_val("spurious_wr", 32'(instwen), 32'd0);
                end else begin
                    exp_wr = sb_q.pop_front();
                    check_val("wr_addr", addwrite, exp_wr.addr);
                    check_val("wr_data", instrdatain, exp_wr.data);
                end
            end else begin
                check_val("idle_bus", addwrite | instrdatain, 32'd0);
            end
        end
    end

    task automatic check_reset_vals();
        check_val("rst_byte_ready", 32'(byte_ready), 32'd0);
        check_val("rst_instwen",    32'(instwen),    32'd0);
        check_val("rst_addwrite",   addwrite,        32'd0);
        check_val("rst_instrdata",  instrdatain,     32'd0);
        check_val("rst_cpu_hold",   32'(cpu_hold),   32'd1);
        check_val("rst_busy",       32'(busy),       32'd0);
        check_val("rst_done",       32'(done),       32'd0);
        check_val("rst_err",        32'(err),        32'd0);
        check_val("rst_word_count", 32'(word_count), 32'd0);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        check_val("start_busy", 32'(busy),       32'd1);
        check_val("start_done", 32'(done),       32'd0);
        check_val("start_err",  32'(err),        32'd0);
        check_val("start_wc",   32'(word_count), 32'd0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap_pct);
        bit ok = 1'b0;
        if (gap_pct > 0) begin
            while ($urandom_range(99) < gap_pct) begin
                @(negedge clk) byte_valid = 1'b0;
            end
        end
        for (int t = 0; t < 200 && !ok; t++) begin
            @(negedge clk);
            byte_valid = 1'b1;
            byte_data  = b;
            if (byte_ready) begin
                ok = 1'b1;
                @(posedge clk);
            end
        end
        if (!ok) check_val("byte_timeout", 32'(byte_ready), 32'd1);
    endtask

    task automatic send_word(input int k, input int gap_pct);
        sb_q.push_back('{addr: c_base + 32'(k) * 32'd4, data: words[k]});
        for (int b = 3; b >= 0; b--) send_byte(words[k][8*b +: 8], gap_pct);
    endtask

    task automatic run_load(input logic [15:0] len, input int nwords, input int gap_pct);
        send_byte(len[15:8], gap_pct);
        send_byte(len[7:0], gap_pct);
        for (int k = 0; k < nwords; k++) send_word(k, gap_pct);
        @(negedge clk) byte_valid = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        bit seen = 1'b0;
        for (int t = 0; t < bound && !seen; t++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check_val("done_seen", 32'(done), 32'd1);
    endtask

    int  w0;
    bit  any_ready;

    initial begin
        reset = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
        repeat (2) @(negedge clk);
        check_reset_vals();
        @(negedge clk) reset = 1'b1;

        // Two-word reference program, back-to-back bytes
        words[0] = 32'h2408_0005;
        words[1] = 32'h2009_0007;
        w0 = wr_cnt;
        pulse_start();
        run_load(16'd2, 2, 0);
        wait_done(20);
        check_val("t1_wc",      32'(word_count),        32'd2);
        check_val("t1_hold",    32'(cpu_hold),          32'd0);
        check_val("t1_err",     32'(err),               32'd0);
        check_val("t1_busy",    32'(busy),              32'd0);
        check_val("t1_writes",  32'(wr_cnt - w0),       32'd2);
        check_val("t1_spacing", 32'(last_wr_cyc - prev_wr_cyc), 32'd5);
        check_val("t1_sb",      32'(sb_q.size()),       32'd0);

        // Empty program
        w0 = wr_cnt;
        pulse_start();
        run_load(16'd0, 0, 0);
        wait_done(20);
        check_val("t2_err",    32'(err),          32'd0);
        check_val("t2_hold",   32'(cpu_hold),     32'd0);
        check_val("t2_wc",     32'(word_count),   32'd0);
        check_val("t2_writes", 32'(wr_cnt - w0),  32'd0);

        // Oversize program: error, stream not consumed
        w0 = wr_cnt;
        pulse_start();
        run_load(16'h0101, 0, 0);
        wait_done(20);
        check_val("t3_err",  32'(err),      32'd1);
        check_val("t3_hold", 32'(cpu_hold), 32'd1);
        check_val("t3_busy", 32'(busy),     32'd0);
        any_ready = 1'b0;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            byte_valid = 1'b1;
            byte_data  = 8'hA5;
            any_ready  = any_ready | byte_ready;
        end
        byte_valid = 1'b0;
        check_val("t3_no_consume", 32'(any_ready),   32'd0);
        check_val("t3_writes",     32'(wr_cnt - w0), 32'd0);

        // Largest accepted length
        for (int k = 0; k < 256; k++) words[k] = $urandom;
        w0 = wr_cnt;
        pulse_start();
        run_load(16'd256, 256, 0);
        wait_done(20);
        check_val("t4_err",    32'(err),         32'd0);
        check_val("t4_wc",     32'(word_count),  32'd256);
        check_val("t4_writes", 32'(wr_cnt - w0), 32'd256);
        check_val("t4_sb",     32'(sb_q.size()), 32'd0);

        // Same 3-word program without and with random byte_valid gaps
        for (int k = 0; k < 3; k++) words[k] = $urandom;
        for (int pass = 0; pass < 2; pass++) begin
            w0 = wr_cnt;
            pulse_start();
            run_load(16'd3, 3, (pass == 0) ? 0 : 40);
            wait_done(20);
            check_val("t5_wc",     32'(word_count),  32'd3);
            check_val("t5_writes", 32'(wr_cnt - w0), 32'd3);
            check_val("t5_sb",     32'(sb_q.size()), 32'd0);
        end

        // Reset after the second byte of word 1, then a clean reload
        words[0] = 32'hDEAD_BEEF;
        words[1] = 32'h0123_4567;
        w0 = wr_cnt;
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(words[0][31:24], 0);
        send_byte(words[0][23:16], 0);
        #2 reset = 1'b0;
        #1 check_reset_vals();
        sb_q.delete();
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        check_val("t6_no_write", 32'(wr_cnt - w0), 32'd0);
        reset = 1'b1;
        pulse_start();
        run_load(16'd2, 2, 0);
        wait_done(20);
        check_val("t6_wc",     32'(word_count),  32'd2);
        check_val("t6_writes", 32'(wr_cnt - w0), 32'd2);
        check_val("t6_sb",     32'(sb_q.size()), 32'd0);

        // Start pulse in the middle of DATA is ignored
        words[0] = 32'hCAFE_0001;
        words[1] = 32'hCAFE_0002;
        w0 = wr_cnt;
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        sb_q.push_back('{addr: c_base, data: words[0]});
        send_byte(words[0][31:24], 0);
        send_byte(words[0][23:16], 0);
        @(negedge clk);
        start = 1'b1;
        byte_valid = 1'b0;
        @(negedge clk) start = 1'b0;
        check_val("t7_busy", 32'(busy), 32'd1);
        send_byte(words[0][15:8], 0);
        send_byte(words[0][7:0], 0);
        send_word(1, 0);
        @(negedge clk) byte_valid = 1'b0;
        wait_done(20);
        check_val("t7_wc",     32'(word_count),  32'd2);
        check_val("t7_writes", 32'(wr_cnt - w0), 32'd2);
        check_val("t7_sb",     32'(sb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_instr_boot_loader
`default_nettype wire
